// File: rtl/adder_harness_pkg.sv
// Shared definitions for the adder test harness.
// Holds the responder FSM state encodings and the default operand/sum widths.
// The serial responder, the tester and the handshake checker all import these.
package adder_harness_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 14;
    localparam int SUM_W         = DEFAULT_WIDTH + 1;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry, used bit-serially.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous carry clear (asserted on operand load)
//   en         : advance the carry flop by one bit position
//   a, b       : current operand bits
//   s          : sum bit of a, b and the stored carry (combinational)
//   cout       : carry out of this bit (combinational, what the flop captures)
module serial_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic cout
);

    logic r_carry;

    assign s    = a ^ b ^ r_carry;
    assign cout = (a & b) | (a & r_carry) | (b & r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (clr) begin
            r_carry <= 1'b0;
        end else if (en) begin
            r_carry <= cout;
        end
    end

endmodule

// File: rtl/serial_adder_responder.sv
// Bit-serial adder on the responder side of a valid/ready harness.
// Accepts an operand pair, adds LSB-first one bit per clock, then presents
// the WIDTH+1 bit sum until the initiator takes it.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, op_ready=1
//   ADD   | shifting one bit per cycle through the full-adder cell
//   DONE  | sum_valid=1, sum held; may retire and accept in one edge
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid/op_ready   : operand handshake (operand1, operand2 unsigned)
//   sum_valid/sum_ready : result handshake (sum is WIDTH+1 bits, carry in MSB)
//   busy                : high whenever not IDLE
module serial_adder_responder
    import adder_harness_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_sum;

    logic w_s;
    logic w_cout;
    logic w_accept;
    logic w_in_add;
    logic w_last;

    // Gated by rst_n so op_ready reads low while reset is held, even though
    // the state register already sits at IDLE.
    assign op_ready  = rst_n & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & sum_ready));
    assign w_accept  = op_valid & op_ready;
    assign w_in_add  = (r_state == ST_ADD);
    assign w_last    = w_in_add & (r_cnt == CNT_W'(WIDTH - 1));

    assign sum_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum       = r_sum;

    serial_fa_cell u_fa (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .en    (w_in_add),
        .a     (r_a[0]),
        .b     (r_b[0]),
        .s     (w_s),
        .cout  (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (w_accept) begin
            // Covers both a fresh accept from IDLE and retire+accept in DONE.
            r_state <= ST_ADD;
            r_a     <= operand1;
            r_b     <= operand2;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ADD: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_acc <= {w_s, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // The last sum bit and final carry go straight to the
                        // output register so sum stays put through IDLE/ADD.
                        r_sum   <= {w_cout, w_s, r_acc[WIDTH-1:1]};
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (sum_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_responder.sv
module tb_serial_adder_responder;
    import adder_harness_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic           clk;
    logic           rst_n;
    logic           op_valid;
    logic           op_ready;
    logic [W-1:0]   operand1;
    logic [W-1:0]   operand2;
    logic           sum_valid;
    logic           sum_ready;
    logic [SUM_W-1:0] sum;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_responder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum       (sum),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = free, 1 = computing (m_left edges to go),
    // 2 = holding a result. The sum is plain integer addition.
    int               m_phase;
    int               m_left;
    logic [SUM_W-1:0] m_sum;
    logic [SUM_W-1:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_sum   <= '0;
            m_pend  <= '0;
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_phase <= 2;
                m_sum   <= m_pend;
            end
        end else if (op_valid && (m_phase == 0 || sum_ready)) begin
            m_phase <= 1;
            m_left  <= W;
            m_pend  <= SUM_W'(operand1) + SUM_W'(operand2);
        end else if (m_phase == 2 && sum_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("op_ready", 32'(op_ready), 32'(rst_n && (m_phase == 0 || (m_phase == 2 && sum_ready))));
        chk("sum_valid", 32'(sum_valid), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("sum", 32'(sum), 32'(m_sum));
    end

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        operand1 = a;
        operand2 = b;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        operand1 = W'($urandom);
        operand2 = W'($urandom);
    endtask

    // Called one time unit after the accept edge.
    task automatic wait_done(input string name, input logic [SUM_W-1:0] exp);
        int k;
        k = 0;
        while (!sum_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (!sum_valid) chk({name, "_ready_low"}, 32'(op_ready), 32'(0));
        end
        chk({name, "_latency"}, 32'(k), 32'(W));
        chk({name, "_sum"}, 32'(sum), 32'(exp));
        chk({name, "_model"}, 32'(m_sum), 32'(exp));
    endtask

    task automatic retire();
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        chk("retire_valid", 32'(sum_valid), 32'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        sum_ready = 1'b0;
        operand1  = '0;
        operand2  = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_op_ready", 32'(op_ready), 32'(1));
        chk("rst_sum_valid", 32'(sum_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        accept(14'd1, 14'd1);
        wait_done("basic", 15'h0002);
        retire();

        accept(14'h3FFF, 14'h3FFF);
        wait_done("max", 15'h7FFE);
        retire();
        accept(14'h3FFF, 14'h0001);
        wait_done("carry", 15'h4000);
        retire();

        accept(14'h1234, 14'h0ABC);
        wait_done("bp", 15'h1CF0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(sum_valid), 32'(1));
            chk("bp_hold_sum", 32'(sum), 32'h1CF0);
        end
        retire();

        accept(14'd100, 14'd200);
        wait_done("b2b_first", 15'd300);
        operand1  = 14'd5;
        operand2  = 14'd7;
        op_valid  = 1'b1;
        sum_ready = 1'b1;
        #1 chk("b2b_ready", 32'(op_ready), 32'(1));
        @(posedge clk); #1;
        op_valid  = 1'b0;
        sum_ready = 1'b0;
        chk("b2b_busy", 32'(busy), 32'(1));
        chk("b2b_valid_low", 32'(sum_valid), 32'(0));
        wait_done("b2b_second", 15'd12);
        retire();

        accept(14'h2AAA, 14'h1555);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(sum_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_ready", 32'(op_ready), 32'(0));
        chk("mid_rst_sum", 32'(sum), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 32'(sum_valid), 32'(0));
        end
        accept(14'd3, 14'd4);
        wait_done("post_rst", 15'd7);
        retire();

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            op_valid  = ($urandom_range(0, 3) != 0);
            sum_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 4))
                0:       operand1 = '1;
                1:       operand1 = '0;
                default: operand1 = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       operand2 = '1;
                1:       operand2 = '0;
                default: operand2 = W'($urandom);
            endcase
        end
        op_valid  = 1'b0;
        sum_ready = 1'b1;
        repeat (2 * W + 4) @(posedge clk);
        #1 chk("drain_idle", 32'(busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
